spdif_receiver: RTL



---
 rtl/spdif_pkg.sv | 71 +++++++
 rtl/bmc_edge_timer.sv | 70 +++++++
 rtl/spdif_receiver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spdif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spdif_pkg
//  Description : Shared types and interval thresholds for the biphase-mark
//                receiver (and a future transmitter preamble update).
//                  state_t  - receiver FSM states
//                  iv_t     - classification of a transition interval
//                  cnt_w()  - interval counter width for a given OSR
//                  thr_*()  - class boundaries as functions of OSR
//                  classify() - map an interval length to an iv_t
//  Revision    : 1.0 - initial release
// ============================================================================
package spdif_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PRE2 = 2'd1,
    DATA = 2'd2,
    HALF = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    GLITCH = 3'd0,
    SHORT  = 3'd1,
    LONG   = 3'd2,
    SYNC   = 3'd3,
    OVER   = 3'd4
  } iv_t;

  // Wide enough to hold the saturation value 2*OSR.
  function automatic int cnt_w(input int osr);
    return $clog2(2 * osr) + 1;
  endfunction

  function automatic int thr_short(input int osr);
    return osr / 4;
  endfunction

  function automatic int thr_long(input int osr);
    return (3 * osr) / 4;
  endfunction

  function automatic int thr_sync(input int osr);
    return (5 * osr) / 4;
  endfunction

  function automatic int thr_sync_max(input int osr);
    return (7 * osr) / 4;
  endfunction

  // First counter value that is too long to be any legal interval.
  function automatic int thr_over(input int osr);
    return thr_sync_max(osr) + 1;
  endfunction

  function automatic iv_t classify(input int osr, input int cnt);
    if (cnt < thr_short(osr)) begin
      return GLITCH;
    end else if (cnt < thr_long(osr)) begin
      return SHORT;
    end else if (cnt < thr_sync(osr)) begin
      return LONG;
    end else if (cnt <= thr_sync_max(osr)) begin
      return SYNC;
    end else begin
      return OVER;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_edge_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bmc_edge_timer
//  Description : Line front end for the biphase-mark receiver. Synchronises
//                the serial line, detects transitions, measures the interval
//                since the previous transition and classifies it.
//  Ports       : clock     - sampling clock (OSR x bit rate)
//                nreset    - asynchronous active-low reset
//                serial_i  - raw line, asynchronous to clock
//                edge_o    - a transition was detected this cycle
//                tmo_o     - line has been quiet for longer than any legal
//                            interval (single-cycle pulse, never with edge_o)
//                class_o   - interval class; OVER whenever edge_o is low
//  Revision    : 1.0 - initial release
// ============================================================================
module bmc_edge_timer
  import spdif_pkg::*;
#(
  parameter int OSR = 8
) (
  input  logic clock,
  input  logic nreset,
  input  logic serial_i,
  output logic edge_o,
  output logic tmo_o,
  output iv_t  class_o
);

  localparam int              CNT_W   = cnt_w(OSR);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 * OSR);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(thr_over(OSR));

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= CNT_SAT;
    end else begin
      s1_q  <= serial_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
    end
  end

  assign edge_o = s2_q ^ s3_q;

  // Reload to 1 so that an interval of N cycles reads as cnt == N at the
  // next edge; saturation keeps a long-idle line from wrapping into a
  // legal-looking interval.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_o) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The counter passes CNT_TMO exactly once per quiet period, so the timeout
  // is naturally a single pulse. The post-reset saturated value never fires it.
  assign tmo_o   = !edge_o && (cnt_q == CNT_TMO);
  assign class_o = edge_o ? classify(OSR, int'(cnt_q)) : OVER;

endmodule
`default_nettype wire

// File: rtl/spdif_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spdif_receiver
//  Description : Biphase-mark receiver. Locks to a 1.5/0.5-cell preamble,
//                decodes WIDTH data bits LSB first and strobes each word out.
//  Ports       : clock     - sampling clock (OSR x bit rate)
//                nreset    - asynchronous active-low reset
//                SerialIn  - biphase-mark line, asynchronous to clock
//                Rx        - last decoded word, held until the next one
//                RxValid   - one-cycle strobe when Rx updates
//                CodeErr   - one-cycle strobe on a coding violation
//                Locked    - high from the first good word until an error
//  Revision    : 1.0 - initial release
// ============================================================================
module spdif_receiver
  import spdif_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OSR   = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] Rx,
  output logic             RxValid,
  output logic             CodeErr,
  output logic             Locked
);

  localparam int               IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

  logic edge_w, tmo_w, ev;
  iv_t  iv;

  bmc_edge_timer #(
    .OSR(OSR)
  ) u_timer (
    .clock   (clock),
    .nreset  (nreset),
    .serial_i(SerialIn),
    .edge_o  (edge_w),
    .tmo_o   (tmo_w),
    .class_o (iv)
  );

  // A timeout is presented to the FSM as an OVER interval.
  assign ev = edge_w | tmo_w;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             shift_en, bit_in;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    shift_en = 1'b0;
    bit_in   = 1'b0;

    if (ev) begin
      unique case (state_q)
        // Anything but a preamble's long interval is ignored while hunting.
        HUNT: begin
          if (iv == SYNC) begin
            state_d = PRE2;
          end
        end
        PRE2: begin
          if (iv == SHORT) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        DATA: begin
          case (iv)
            LONG: begin
              shift_en = 1'b1;
              bit_in   = 1'b0;
            end
            SHORT: state_d = HALF;
            // A preamble mid-word: abandon the word and resync on it.
            SYNC: begin
              err_d   = 1'b1;
              state_d = PRE2;
            end
            default: begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          endcase
        end
        HALF: begin
          case (iv)
            SHORT: begin
              shift_en = 1'b1;
              bit_in   = 1'b1;
            end
            SYNC: begin
              err_d   = 1'b1;
              state_d = PRE2;
            end
            default: begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          endcase
        end
      endcase

      if (shift_en) begin
        sh_d = {bit_in, sh_q[WIDTH-1:1]};
        if (idx_q == LAST) begin
          // The closing edge is also the first preamble edge of the next
          // frame, so HUNT sees the following long interval as SYNC.
          rx_d     = sh_d;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          idx_d    = '0;
          state_d  = HUNT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DATA;
        end
      end

      if (err_d) begin
        locked_d = 1'b0;
        idx_d    = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign Rx      = rx_q;
  assign RxValid = valid_q;
  assign CodeErr = err_q;
  assign Locked  = locked_q;

endmodule
`default_nettype wire
